// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: U-type opcodes, datapath width and the
// result-queue entry layout used by the U-type execute stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;

  typedef struct packed {
    logic            we;
    logic            illegal;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } utype_entry_t;

endpackage

// File: rtl/utype_result_fifo.sv
// Circular result queue: DEPTH entries of WIDTH bits, natural pointer wrap.
// Storage is not reset; only pointers and occupancy are.
module utype_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/riscv_utype_exec.sv
// LUI/AUIPC execute stage feeding a small writeback queue.
// Define RISCV_UTYPE_EXEC_PERF_EN to add retired/illegal pop counters.
module riscv_utype_exec
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [19:0] in_imm,
  input  logic [4:0]  in_rd,
  input  logic [6:0]  in_opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_rd_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rd_data,
  output logic        out_illegal
`ifdef RISCV_UTYPE_EXEC_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_illegal
`endif
);

  localparam int EW = $bits(utype_entry_t);

  function automatic utype_entry_t utype_compute(
    input logic [XLEN-1:0] pc,
    input logic [19:0]     imm,
    input logic [4:0]      rd,
    input logic [6:0]      opc
  );
    utype_entry_t  e;
    logic [XLEN-1:0] u;
    u  = {imm, 12'h000};
    e  = '0;
    e.rd = rd;
    case (opc)
      OPC_LUI:   e.data = u;
      OPC_AUIPC: e.data = pc + u;
      default:   e.illegal = 1'b1;
    endcase
    e.we = !e.illegal && (rd != 5'd0);
    return e;
  endfunction

  // Stage p0: result computed combinationally at the push boundary
  utype_entry_t     entry_p0;
  logic             push_p0;
  logic             pop_p1;
  logic [EW-1:0]    head_raw_p1;
  utype_entry_t     head_p1;
  logic             full_p1;
  logic             empty_p1;

  assign entry_p0 = utype_compute(in_pc, in_imm, in_rd, in_opcode);
  assign in_ready = !full_p1;
  assign push_p0  = in_valid && in_ready;

  utype_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_p0),
    .wdata (entry_p0),
    .pop   (pop_p1),
    .rdata (head_raw_p1),
    .full  (full_p1),
    .empty (empty_p1)
  );

  // Stage p1: registered queue head presented to writeback
  assign head_p1     = utype_entry_t'(head_raw_p1);
  assign out_valid   = !empty_p1;
  assign pop_p1      = out_valid && out_ready;
  assign out_rd_we   = out_valid && head_p1.we;
  assign out_illegal = out_valid && head_p1.illegal;
  assign out_rd      = out_valid ? head_p1.rd   : 5'd0;
  assign out_rd_data = out_valid ? head_p1.data : '0;

`ifdef RISCV_UTYPE_EXEC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_illegal <= '0;
    end else if (pop_p1) begin
      perf_retired <= perf_retired + 32'd1;
      if (head_p1.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_utype_exec.sv
// Scoreboard bench for riscv_utype_exec: expected entries queued at push,
// compared at pop. Honours RISCV_UTYPE_EXEC_PERF_EN for the perf counters.
module tb_riscv_utype_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [19:0] in_imm;
  logic [4:0]  in_rd;
  logic [6:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic        out_rd_we;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_data;
  logic        out_illegal;
`ifdef RISCV_UTYPE_EXEC_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_illegal;
`endif

  riscv_utype_exec #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .in_opcode   (in_opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd_we   (out_rd_we),
    .out_rd      (out_rd),
    .out_rd_data (out_rd_data),
    .out_illegal (out_illegal)
`ifdef RISCV_UTYPE_EXEC_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_illegal (perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_retired = 0;
  int   exp_illegal = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc, input logic [19:0] imm,
                                 input logic [4:0] rd, input logic [6:0] opc);
    exp_t e;
    e.rd = rd;
    e.ill = 1'b0;
    if (opc == 7'h37)      e.data = {imm, 12'h000};
    else if (opc == 7'h17) e.data = pc + {imm, 12'h000};
    else begin
      e.data = 32'h0;
      e.ill  = 1'b1;
    end
    e.we = !e.ill && (rd != 5'd0);
    return e;
  endfunction

  // Monitor: both handshakes complete on the coming rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pop_rd",   {27'd0, out_rd}, {27'd0, e.rd});
          check("pop_data", out_rd_data, e.data);
          check("pop_we",   {31'd0, out_rd_we}, {31'd0, e.we});
          check("pop_ill",  {31'd0, out_illegal}, {31'd0, e.ill});
          exp_retired++;
          if (e.ill) exp_illegal++;
        end
      end else if (!out_valid) begin
        check("idle_zero", {out_rd_we, out_illegal, out_rd, out_rd_data[24:0]} | out_rd_data, 32'd0);
      end
      if (in_valid && in_ready) sb.push_back(model(in_pc, in_imm, in_rd, in_opcode));
    end
  end

  task automatic send(input logic [31:0] pc, input logic [19:0] imm,
                      input logic [4:0] rd, input logic [6:0] opc);
    int t = 0;
    in_pc = pc; in_imm = imm; in_rd = rd; in_opcode = opc; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      t++;
      if (t > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 || out_valid) begin
      @(posedge clk); #1;
      t++;
      if (t > 50) begin
        check("drain_timeout", sb.size(), 0);
        break;
      end
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef RISCV_UTYPE_EXEC_PERF_EN
    check({tag, "_retired"}, perf_retired, exp_retired);
    check({tag, "_illegal"}, perf_illegal, exp_illegal);
`else
    check({tag, "_sb_empty"}, sb.size(), 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rd = '0;
    in_opcode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_data",      out_rd_data, 32'd0);
    check_perf("rst_perf");

    out_ready = 1'b1;
    send(32'h0, 20'h12345, 5'd5, 7'h37);
    check("lui_valid", {31'd0, out_valid}, 32'd1);
    check("lui_rd",    {27'd0, out_rd}, 32'd5);
    check("lui_data",  out_rd_data, 32'h12345000);
    check("lui_we",    {31'd0, out_rd_we}, 32'd1);
    check("lui_ill",   {31'd0, out_illegal}, 32'd0);
    drain();

    send(32'h00001000, 20'hFFFFF, 5'd7, 7'h17);
    check("auipc_wrap", out_rd_data, 32'h00000000);
    check("auipc_wrap_we", {31'd0, out_rd_we}, 32'd1);
    send(32'h00000010, 20'h00001, 5'd8, 7'h17);
    check("auipc_add", out_rd_data, 32'h00001010);
    drain();

    begin
      logic [31:0] w;
      w = 32'habcdef12;
      send(32'h100, w[31:12], w[11:7], w[6:0]);
    end
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_we",   {31'd0, out_rd_we}, 32'd0);
    check("ill_data", out_rd_data, 32'd0);
    check("ill_rd",   {27'd0, out_rd}, 32'd30);
    drain();
    check_perf("ill_perf");

    send(32'h0, 20'hFFFFF, 5'd0, 7'h37);
    check("x0_data", out_rd_data, 32'hFFFFF000);
    check("x0_we",   {31'd0, out_rd_we}, 32'd0);
    check("x0_ill",  {31'd0, out_illegal}, 32'd0);
    drain();

    // Backpressure: fill, refuse a third, then release in order
    out_ready = 1'b0;
    send(32'h0, 20'h00001, 5'd1, 7'h37);
    send(32'h0, 20'h00002, 5'd2, 7'h37);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_imm = 20'h00003; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_no_accept", sb.size(), 2);
    check("full_head", out_rd_data, 32'h00001000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    check("bp_second", out_rd_data, 32'h00002000);
    drain();

    // Continuous stream across pointer wrap
    for (int i = 0; i < 9; i++) begin
      in_pc = 32'h4000 + i * 4; in_imm = 20'h00100 + i[19:0]; in_rd = 5'(i + 1);
      in_opcode = (i % 2 == 0) ? 7'h17 : 7'h37; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with two entries pending
    out_ready = 1'b0;
    send(32'h0, 20'hAAAAA, 5'd3, 7'h37);
    send(32'h0, 20'hBBBBB, 5'd4, 7'h37);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    exp_retired = 0;
    exp_illegal = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid",    {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_perf("post_rst_perf");
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_stays_empty", {31'd0, out_valid}, 32'd0);
    send(32'h0, 20'h00042, 5'd9, 7'h37);
    check("post_rst_new", out_rd_data, 32'h00042000);
    drain();
    check_perf("final_perf");
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_utype_exec.md
Name: riscv_utype_exec

Overview:
- Execute stage directly downstream of the U-type field decoder. Consumes the decoded {imm[19:0], rd[4:0], opcode[6:0]} plus the instruction PC.
- Computes the LUI/AUIPC result and queues a register-file write request for writeback.
- Valid/ready on both sides; an internal DEPTH-entry result queue absorbs writeback backpressure.

Parameters:
- DEPTH, 2, result-queue entries; power of two, ≥2.
- XLEN, 32, datapath width; fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts input this cycle
- in_pc  in  32  PC of the instruction
- in_imm  in  20  U-type immediate (inst[31:12])
- in_rd  in  5  destination register
- in_opcode  in  7  opcode (inst[6:0])
- out_valid  out  1  queue head valid
- out_ready  in  1  writeback consumes head
- out_rd_we  out  1  register write enable for head
- out_rd  out  5  destination register of head
- out_rd_data  out  32  result of head
- out_illegal  out  1  head carried a non-U-type opcode

Behaviour:
- Handshake rules:
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready.
  - out_valid = (count != 0). Head fields come straight from registers.
- Result computation (at push, combinational):
  - U = {in_imm, 12'h000}.
  - LUI (7'h37): data = U.
  - AUIPC (7'h17): data = in_pc + U, mod 2^32 (carry discarded).
  - Any other opcode: data = 0, illegal = 1, we = 0.
  - we = legal && (in_rd != 0). For rd = x0, data is still computed and queued with we = 0.
- Latency: the pushed entry is visible at out_* on the next cycle when the queue was empty. No combinational bypass.
- Queue:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping naturally, and count of log2(DEPTH)+1 bits.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - Full: push is impossible because in_ready = 0; a pop frees a slot and in_ready rises the following cycle.
  - Empty: pop is impossible because out_valid = 0.
  - A push to an empty queue with out_ready high is popped the next cycle at the earliest.
- Entries are accepted without regard to rd hazards. Forwarding is out of scope.
- Reset (asynchronous, any time, including mid-transfer):
  - count, wr_ptr, rd_ptr = 0; out_valid = 0; in_ready = 1 from the first edge after deassertion.
  - out_rd_we = 0, out_illegal = 0, out_rd = 0, out_rd_data = 0.
  - Queued entries are discarded and storage contents are don't-care.
- out_rd_we, out_illegal, out_rd and out_rd_data are forced to 0 whenever out_valid = 0.

Optional Feature:
- Macro: RISCV_UTYPE_EXEC_PERF_EN.
- Defined:
  - Adds outputs perf_retired[31:0] and perf_illegal[31:0].
  - perf_retired increments on every pop; perf_illegal increments on every pop whose head has illegal = 1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist. Functional behaviour is identical in both cases.

Decomposition:
- Shared package riscv_pkg holds:
  - OPC_LUI = 7'h37, OPC_AUIPC = 7'h17
  - XLEN
  - the queue entry struct {we, illegal, rd[4:0], data[31:0]}
- One sub-module, utype_result_fifo: parameterised DEPTH/width storage with count/pointers.
- riscv_utype_exec keeps the compute logic, handshake glue and optional perf counters.

Test Plan:
- LUI, rd=5, imm=20'h12345, out_ready=1 -> next cycle out_valid=1, out_rd=5, out_rd_data=32'h12345000, out_rd_we=1, out_illegal=0.
- AUIPC, pc=32'h00001000, imm=20'hFFFFF -> out_rd_data=32'h00000000 (wrap), out_rd_we=1. Also pc=32'h00000010, imm=20'h00001 -> 32'h00001010.
- Instruction word 32'habcdef12 decoded (opcode 7'h12, rd=30) -> out_illegal=1, out_rd_we=0, out_rd_data=0. Under PERF_EN, perf_illegal=1 after the pop.
- LUI with rd=0, imm=20'hFFFFF -> out_rd_data=32'hFFFFF000, out_rd_we=0, out_illegal=0.
- Backpressure:
  - Hold out_ready=0 and push DEPTH=2 LUIs (imm 1, 2) -> in_ready=0, and a third in_valid is not accepted.
  - Raise out_ready -> pops occur in order with data 32'h00001000 then 32'h00002000; in_ready returns to 1 the cycle after the first pop.
  - With continuous push and pop for 8 cycles -> every pop returns the entry pushed exactly one cycle earlier, with no loss across pointer wrap.
- With 2 entries queued, assert rst_n=0 mid-cycle -> out_valid=0 and in_ready=1 immediately after the first clock edge following deassertion, the old entries never appear, and the PERF counters read 0.
